// File: rtl/rom_reader_pkg.sv
// Shared types and default widths for the ROM burst reader.
package rom_reader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // Burst controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rom_rd_skid_fifo.sv
// Two-entry FIFO holding ROM words plus their end-of-burst flag.
// The head entry is presented directly, so the output stays put while stalled.
module rom_rd_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              head_last_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_data_q [2];
    logic              mem_last_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              do_push;
    logic              do_pop;

    // Qualify push/pop against occupancy and compute next count
    always_comb begin
        do_push = push_i && (count_q != 2'd2);
        do_pop  = pop_i && (count_q != 2'd0);
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Storage and pointer updates; reset empties the FIFO and clears contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_data_q[wr_ptr_q] <= push_data_i;
                mem_last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_data_o = mem_data_q[rd_ptr_q];
    assign head_last_o = mem_last_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/rom_burst_reader.sv
// Reads a burst of consecutive ROM words (1-cycle read latency) and streams
// them out. Stream handshake: a word moves when m_valid && m_ready in the
// same cycle; m_valid/m_data/m_last hold steady while m_valid && !m_ready.
// Reads are throttled so buffered plus outstanding words never exceed the
// two FIFO entries, while still sustaining one word per cycle.
module rom_burst_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_rd_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output rd_state_e         dbg_state
);

    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    rd_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q;

    logic [1:0]        fifo_count;
    logic              head_last;
    logic              pop;
    logic [2:0]        occ;
    logic              rd_room;
    logic              rd_en;
    logic              rd_last;

    // Read issue decision: a slot freed by this cycle's pop may be reused now
    always_comb begin
        pop     = m_valid && m_ready;
        occ     = {1'b0, fifo_count} + {2'b0, inflight_q};
        rd_room = pop ? (occ < 3'd3) : (occ < 3'd2);
        rd_en   = (state_q == ST_RUN) && (remain_q != '0) && rd_room;
        rd_last = (remain_q == REM_ONE);
    end

    // Burst FSM with address, remaining-read counter and in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && rd_last;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state_q  <= ST_RUN;
                            addr_q   <= start_addr;
                            remain_q <= length;
                        end else begin
                            // Empty burst completes immediately without reads
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_en) begin
                        addr_q   <= addr_q + ADDR_ONE;
                        remain_q <= remain_q - REM_ONE;
                        if (rd_last) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_last) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    rom_rd_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (rom_data),
        .push_last_i (inflight_last_q),
        .pop_i       (pop),
        .head_data_o (m_data),
        .head_last_o (head_last),
        .count_o     (fifo_count)
    );

    assign rom_rd_en   = rd_en;
    assign rom_rd_addr = addr_q;
    assign m_valid     = (fifo_count != 2'd0);
    assign m_last      = m_valid && head_last;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a 1-cycle-latency ROM model.
module tb_rom_burst_reader;
    import rom_reader_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          rom_rd_en;
    logic [AW-1:0] rom_rd_addr;
    logic [DW-1:0] rom_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
    rd_state_e     dbg_state;

    rom_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .rom_rd_en   (rom_rd_en),
        .rom_rd_addr (rom_rd_addr),
        .rom_data    (rom_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // ROM model: rom[i] = 0x1000_0000 + i, one cycle after the read strobe
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= 32'h1000_0000 + 32'(rom_rd_addr);
        else           rom_data <= 32'hDEAD_BEEF;
    end

    // Monitor state
    logic [DW:0]   beat_q[$];
    int            beat_cyc_q[$];
    int            cyc = 0;
    int            rd_cnt = 0;
    int            done_cnt = 0;
    int            last_done_cyc = 0;
    int            start_cyc = 0;
    int            first_valid_cyc = -1;
    int            valid_cnt = 0;
    int            busy_cnt = 0;
    int            stall_err = 0;
    int            out_diff = 0;
    int            max_out = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    // Observe the interface away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            out_diff   = 0;
            stall_prev = 1'b0;
        end else begin
            if (rom_rd_en) rd_cnt = rd_cnt + 1;
            if (m_valid) valid_cnt = valid_cnt + 1;
            if (busy) busy_cnt = busy_cnt + 1;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                beat_q.push_back({m_last, m_data});
                beat_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt      = done_cnt + 1;
                last_done_cyc = cyc;
            end
            if (start) start_cyc = cyc;
            if (stall_prev && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stall_err = stall_err + 1;
            out_diff = out_diff + int'(rom_rd_en) - int'(m_valid && m_ready);
            if (out_diff > max_out) max_out = out_diff;
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // scoreboard
    logic [DW:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        beat_q.delete();
        beat_cyc_q.delete();
        first_valid_cyc = -1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] n);
        start      = 1'b1;
        start_addr = a;
        length     = n;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < bound) begin
            tick();
            k++;
        end
        chk(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    // Compare captured beats against the ROM contents for the burst
    task automatic check_burst(input string tag, input logic [AW-1:0] a, input int n);
        logic [DW:0] got;
        logic [DW:0] exp;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] ad;
            ad = a + AW'(i);
            exp_q.push_back({(i == n - 1), 32'h1000_0000 + 32'(ad)});
        end
        chk({tag, "_count"}, 64'(beat_q.size()), 64'(n));
        for (int i = 0; i < n && beat_q.size() > 0; i++) begin
            got = beat_q.pop_front();
            exp = exp_q.pop_front();
            chk({tag, "_beat"}, 64'(got), 64'(exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, v0, b0, s0, t0;

        // Reset values
        repeat (3) tick();
        chk("rst_rd_en", 64'(rom_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rom_rd_addr), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n   = 1'b1;
        m_ready = 1'b1;
        repeat (2) tick();

        // Basic burst at 0x10, length 4
        clear_obs();
        d0 = done_cnt; r0 = rd_cnt;
        pulse_start(8'h10, 9'd4);
        wait_done(d0, 50, "b1_done");
        tick();
        chk("b1_first_valid_lat", 64'(first_valid_cyc - start_cyc), 64'd3);
        chk("b1_reads", 64'(rd_cnt - r0), 64'd4);
        if (beat_cyc_q.size() == 4) begin
            chk("b1_contig", 64'(beat_cyc_q[3] - beat_cyc_q[0]), 64'd3);
            chk("b1_done_lat", 64'(last_done_cyc - beat_cyc_q[3]), 64'd1);
        end
        check_burst("b1", 8'h10, 4);
        chk("b1_idle", 64'(dbg_state), 64'(ST_IDLE));

        // Address wrap
        clear_obs();
        d0 = done_cnt;
        pulse_start(8'hFE, 9'd4);
        wait_done(d0, 50, "b2_done");
        tick();
        check_burst("b2", 8'hFE, 4);

        // Back-pressure: 1-0-0-1 then random
        clear_obs();
        d0 = done_cnt; r0 = rd_cnt; max_out = 0; stall_err = 0;
        pulse_start(8'h30, 9'd8);
        begin
            logic [3:0] pat;
            int k;
            pat = 4'b1001;
            k = 0;
            while (done_cnt == d0 && k < 300) begin
                m_ready = (k < 4) ? pat[3 - k] : 1'($urandom_range(0, 1));
                tick();
                k++;
            end
            chk("b3_done", 64'(done_cnt - d0), 64'd1);
        end
        m_ready = 1'b1;
        tick();
        chk("b3_reads", 64'(rd_cnt - r0), 64'd8);
        chk("b3_stall_stable", 64'(stall_err), 64'd0);
        chk("b3_max_outstanding_le2", 64'(max_out <= 2), 64'd1);
        check_burst("b3", 8'h30, 8);

        // Zero-length burst
        clear_obs();
        d0 = done_cnt; r0 = rd_cnt; v0 = valid_cnt; b0 = busy_cnt;
        pulse_start(8'h55, 9'd0);
        repeat (4) tick();
        chk("z_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("z_done_lat", 64'(last_done_cyc - start_cyc), 64'd1);
        chk("z_reads", 64'(rd_cnt - r0), 64'd0);
        chk("z_valid", 64'(valid_cnt - v0), 64'd0);
        chk("z_busy", 64'(busy_cnt - b0), 64'd0);

        // Start during busy is ignored
        clear_obs();
        d0 = done_cnt; r0 = rd_cnt;
        pulse_start(8'h40, 9'd6);
        tick();
        pulse_start(8'h00, 9'd3);
        wait_done(d0, 60, "ig_done");
        repeat (4) tick();
        chk("ig_done_once", 64'(done_cnt - d0), 64'd1);
        chk("ig_reads", 64'(rd_cnt - r0), 64'd6);
        check_burst("ig", 8'h40, 6);

        // Full 256-word burst
        clear_obs();
        d0 = done_cnt; r0 = rd_cnt; v0 = valid_cnt;
        pulse_start(8'h80, 9'd256);
        wait_done(d0, 400, "f_done");
        tick();
        chk("f_reads", 64'(rd_cnt - r0), 64'd256);
        chk("f_valid_cycles", 64'(valid_cnt - v0), 64'd256);
        chk("f_first_valid_lat", 64'(first_valid_cyc - start_cyc), 64'd3);
        if (beat_cyc_q.size() == 256)
            chk("f_contig", 64'(beat_cyc_q[255] - beat_cyc_q[0]), 64'd255);
        check_burst("f", 8'h80, 256);

        // Reset in the middle of a 16-word burst
        clear_obs();
        d0 = done_cnt;
        pulse_start(8'h20, 9'd16);
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rd_en", 64'(rom_rd_en), 64'd0);
        chk("mr_rd_addr", 64'(rom_rd_addr), 64'd0);
        chk("mr_m_valid", 64'(m_valid), 64'd0);
        chk("mr_m_data", 64'(m_data), 64'd0);
        chk("mr_m_last", 64'(m_last), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mr_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mr_no_valid", 64'(m_valid), 64'd0);
        clear_obs();
        d0 = done_cnt; r0 = rd_cnt;
        pulse_start(8'h33, 9'd3);
        s0 = start_cyc;
        wait_done(d0, 50, "mr2_done");
        tick();
        t0 = first_valid_cyc - s0;
        chk("mr2_first_valid_lat", 64'(t0), 64'd3);
        chk("mr2_reads", 64'(rd_cnt - r0), 64'd3);
        check_burst("mr2", 8'h33, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_burst_reader.md
ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 Parameter ADDR_W, default 8, ROM address width.
REQ-002 Parameter DATA_W, default 32, ROM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  first ROM address of burst.
REQ-007 length  input  ADDR_W+1  word count, 0..256.
REQ-008 rom_rd_en  output  1  ROM read strobe.
REQ-009 rom_rd_addr  output  ADDR_W  ROM read address.
REQ-010 rom_data  input  DATA_W  ROM read data, valid the cycle after rom_rd_en.
REQ-011 m_valid  output  1  stream word available.
REQ-012 m_ready  input  1  downstream accepts word.
REQ-013 m_data  output  DATA_W  stream word.
REQ-014 m_last  output  1  marks final word of burst, qualified by m_valid.
REQ-015 busy  output  1  burst in progress.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start with length!=0; RUN->DRAIN after last read issued; DRAIN->IDLE on last-word handshake.
REQ-018 start with length==0: no reads, no beats, done pulsed the next cycle, FSM stays IDLE.
REQ-019 start while not IDLE SHALL be ignored.
REQ-020 First rom_rd_en SHALL assert the cycle after start accepted, rom_rd_addr=start_addr.
REQ-021 Each subsequent read increments address by 1, wrapping 2^ADDR_W-1 -> 0.
REQ-022 Exactly length reads SHALL be issued per burst; rom_rd_en low in IDLE and DRAIN.
REQ-023 rom_data SHALL be captured into a 2-entry FIFO the cycle after the matching rom_rd_en.
REQ-024 Read issued only when (FIFO count + reads in flight - pop this cycle) < 2; FIFO never overflows.
REQ-025 m_valid = FIFO non-empty; m_data = FIFO head; pop on m_valid && m_ready.
REQ-026 With m_ready held high, throughput SHALL be one word per cycle; first m_valid 3 cycles after start cycle.
REQ-027 m_valid, m_data, m_last SHALL stay stable while m_valid && !m_ready.
REQ-028 m_last high only on the length-th word.
REQ-029 busy high from cycle after start accept through cycle of last handshake, inclusive.
REQ-030 done high exactly one cycle, the cycle after last handshake; busy low then; new start accepted in that cycle.
REQ-031 Words delivered in address order, no drop or duplication under any m_ready pattern.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, FIFO empty, in-flight flag clear, counters zero.
REQ-033 Reset values: rom_rd_en=0, rom_rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
REQ-034 Reset mid-burst discards the burst; no done pulse; ROM data returning after reset ignored.

Structure
REQ-035 Package rom_reader_pkg SHALL hold state enum type and ADDR_W/DATA_W defaults.
REQ-036 2-entry FIFO SHALL be sub-module rom_rd_skid_fifo (data+last, count, push/pop).
REQ-037 Top holds FSM, address counter, remaining-read counter, in-flight flag.

Verification (ROM model: 1-cycle latency, rom[i]=0x1000_0000+i)
REQ-038 start_addr=0x10, length=4, m_ready=1 -> words 0x10000010..0x10000013, m_last on 4th, first m_valid 3 cycles after start, done 1 cycle after last.
REQ-039 start_addr=0xFE, length=4 -> words 0x100000FE, 0x100000FF, 0x10000000, 0x10000001.
REQ-040 length=8, m_ready toggled 1-0-0-1 random -> all 8 words in order, m_data stable while stalled, ≤2 reads outstanding+buffered.
REQ-041 length=0 -> no rom_rd_en, no m_valid, done pulse next cycle; start during busy -> ignored, original burst unaffected.
REQ-042 length=256, start_addr=0x80, m_ready=1 -> 256 beats covering all addresses, 256 contiguous cycles of m_valid.
REQ-043 rst_n low mid-burst of 16 words -> all outputs 0 immediately; next burst after release runs correctly from its own start_addr.
